lsu_bus_arbiter: RTL



---
 rtl/lsu_bus_arbiter.sv | 209 ++++++++++++++++++++
 1 files changed

// File: rtl/lsu_bus_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : lsu_bus_arbiter
//  Description : Shares one req/gnt/rvalid data-memory bus between the fetch
//                unit (IF) and the mem1-stage load/store unit (LS). Buffers
//                one pulse request per port, arbitrates, keeps at most one
//                transaction outstanding, and routes the response back to
//                the owning port as a one-cycle done pulse.
//  Revision    : 1.0 - initial release
// ============================================================================
module lsu_bus_arbiter #(
   parameter int LSU_PRIORITY = 0   // 0: round-robin on ties, 1: LS wins ties
) (
   input  logic        clk_i,
   input  logic        rstn_i,
   // fetch port
   input  logic        if_req_i,
   input  logic [31:0] if_addr_i,
   output logic [31:0] if_rdata_o,
   output logic        if_req_done_o,
   // load/store port
   input  logic        ls_req_i,
   input  logic [31:0] ls_addr_i,
   input  logic        ls_we_i,
   input  logic [3:0]  ls_wsel_byte_i,
   input  logic [31:0] ls_wdata_i,
   output logic [31:0] ls_rdata_o,
   output logic        ls_req_done_o,
   // memory bus
   output logic        mem_req_o,
   output logic [31:0] mem_addr_o,
   output logic        mem_we_o,
   output logic [3:0]  mem_wsel_byte_o,
   output logic [31:0] mem_wdata_o,
   input  logic        mem_gnt_i,
   input  logic        mem_rvalid_i,
   input  logic [31:0] mem_rdata_i
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_REQ  = 2'd1;
   localparam logic [1:0] S_RESP = 2'd2;

   localparam logic P_IF = 1'b0;
   localparam logic P_LS = 1'b1;

   logic [1:0]  r_state;
   logic [1:0]  w_state_nxt;

   logic        r_if_pend;
   logic [31:0] r_if_addr;
   logic        r_ls_pend;
   logic [31:0] r_ls_addr;
   logic        r_ls_we;
   logic [3:0]  r_ls_wsel;
   logic [31:0] r_ls_wdata;

   logic        r_owner;       // port locked onto the bus while in REQ/RESP
   logic        r_last_owner;  // port of the most recent grant (round-robin)

   logic        w_any_pend;
   logic        w_winner;
   logic        w_sel;         // port whose payload is presented this cycle
   logic        w_mem_req;
   logic        w_grant;
   logic        w_if_busy;
   logic        w_ls_busy;
   logic        w_if_accept;
   logic        w_ls_accept;

   // A port is busy while it has a buffered request or owns the bus.
   assign w_if_busy   = r_if_pend || ((r_state != S_IDLE) && (r_owner == P_IF));
   assign w_ls_busy   = r_ls_pend || ((r_state != S_IDLE) && (r_owner == P_LS));
   assign w_if_accept = if_req_i && !w_if_busy;
   assign w_ls_accept = ls_req_i && !w_ls_busy;

   // LS wins when alone, on fixed priority, or when IF held the bus last.
   assign w_any_pend = r_if_pend || r_ls_pend;
   assign w_winner   = (r_ls_pend && (!r_if_pend || (LSU_PRIORITY != 0) ||
                                      (r_last_owner == P_IF))) ? P_LS : P_IF;
   assign w_grant    = w_mem_req && mem_gnt_i;

   // State register.
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state logic: issue from IDLE, hold in REQ until grant, wait in RESP.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:  if (w_any_pend)   w_state_nxt = mem_gnt_i ? S_RESP : S_REQ;
         S_REQ:   if (mem_gnt_i)    w_state_nxt = S_RESP;
         S_RESP:  if (mem_rvalid_i) w_state_nxt = S_IDLE;
         default:                   w_state_nxt = S_IDLE;
      endcase
   end

   // Output logic: bus request/payload and per-port completion routing.
   always_comb begin
      w_mem_req       = 1'b0;
      w_sel           = r_owner;
      mem_addr_o      = 32'd0;
      mem_we_o        = 1'b0;
      mem_wsel_byte_o = 4'd0;
      mem_wdata_o     = 32'd0;
      if_req_done_o   = 1'b0;
      ls_req_done_o   = 1'b0;
      if_rdata_o      = 32'd0;
      ls_rdata_o      = 32'd0;

      case (r_state)
         S_IDLE: begin
            w_mem_req = w_any_pend;
            w_sel     = w_winner;
         end
         S_REQ: begin
            w_mem_req = 1'b1;
         end
         S_RESP: begin
            if (mem_rvalid_i) begin
               if (r_owner == P_LS) begin
                  ls_req_done_o = 1'b1;
                  ls_rdata_o    = mem_rdata_i;
               end else begin
                  if_req_done_o = 1'b1;
                  if_rdata_o    = mem_rdata_i;
               end
            end
         end
         default: begin
            w_mem_req = 1'b0;
         end
      endcase

      if (w_mem_req) begin
         if (w_sel == P_LS) begin
            mem_addr_o      = r_ls_addr;
            mem_we_o        = r_ls_we;
            mem_wsel_byte_o = r_ls_wsel;
            mem_wdata_o     = r_ls_wdata;
         end else begin
            mem_addr_o      = r_if_addr;
            mem_we_o        = 1'b0;
            mem_wsel_byte_o = 4'b1111;
            mem_wdata_o     = 32'd0;
         end
      end
      mem_req_o = w_mem_req;
   end

   // Pending buffers, owner lock and round-robin history.
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         r_if_pend    <= 1'b0;
         r_if_addr    <= 32'd0;
         r_ls_pend    <= 1'b0;
         r_ls_addr    <= 32'd0;
         r_ls_we      <= 1'b0;
         r_ls_wsel    <= 4'd0;
         r_ls_wdata   <= 32'd0;
         r_owner      <= P_IF;
         r_last_owner <= P_IF;
      end else begin
         // A port cannot be accepted and granted in the same cycle: grant
         // requires the pending flag, acceptance requires it clear.
         if (w_if_accept) begin
            r_if_pend <= 1'b1;
            r_if_addr <= if_addr_i;
         end else if (w_grant && (w_sel == P_IF)) begin
            r_if_pend <= 1'b0;
         end

         if (w_ls_accept) begin
            r_ls_pend  <= 1'b1;
            r_ls_addr  <= ls_addr_i;
            r_ls_we    <= ls_we_i;
            r_ls_wsel  <= ls_wsel_byte_i;
            r_ls_wdata <= ls_wdata_i;
         end else if (w_grant && (w_sel == P_LS)) begin
            r_ls_pend <= 1'b0;
         end

         // Lock the winner as owner when leaving IDLE, so a later arrival
         // cannot preempt a request that is waiting for grant.
         if ((r_state == S_IDLE) && w_any_pend) begin
            r_owner <= w_winner;
         end

         if (w_grant) begin
            r_last_owner <= w_sel;
         end
      end
   end

`ifndef SYNTHESIS
   // A new pulse while the same port is still pending or in flight is dropped.
   a_if_req_while_busy: assert property (@(posedge clk_i) disable iff (!rstn_i)
      if_req_i |-> !w_if_busy);
   a_ls_req_while_busy: assert property (@(posedge clk_i) disable iff (!rstn_i)
      ls_req_i |-> !w_ls_busy);
`endif

endmodule
`default_nettype wire
